// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified I/D RAM between the IF and MEM stages.
// MEM is served first (older instruction); the pipeline is frozen until both are served.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  conflict_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_BUSY,
    IF_BUSY
  } state_t;

  state_t            state, stateNext;
  logic              ifDone, memDone;
  logic              ifDoneNext, memDoneNext;
  logic              ramReqNext, ramWeNext;
  logic [ADDR_W-1:0] ramAddrNext;
  logic [DATA_W-1:0] ramWdataNext;
  logic [DATA_W-1:0] ifInstrNext, memRdataNext;
  logic              memReq, ifPending, memPending, boundary;

  // A simultaneous read+write request is handled as a store.
  assign memReq     = mem_read | mem_write;
  assign ifPending  = if_req & ~ifDone;
  assign memPending = memReq & ~memDone;
  assign stall      = ifPending | memPending;
  assign boundary   = ~stall;

  always_comb begin
    stateNext    = state;
    ramReqNext   = ram_req;
    ramWeNext    = ram_we;
    ramAddrNext  = ram_addr;
    ramWdataNext = ram_wdata;
    ifDoneNext   = ifDone;
    memDoneNext  = memDone;
    ifInstrNext  = if_instr;
    memRdataNext = mem_rdata;

    case (state)
      IDLE: begin
        if (memPending) begin
          ramReqNext   = 1'b1;
          ramWeNext    = mem_write;
          ramAddrNext  = mem_addr;
          ramWdataNext = mem_wdata;
          stateNext    = MEM_BUSY;
        end else if (ifPending) begin
          ramReqNext  = 1'b1;
          ramWeNext   = 1'b0;
          ramAddrNext = if_addr;
          stateNext   = IF_BUSY;
        end
      end

      MEM_BUSY: begin
        if (ram_ack) begin
          memDoneNext = 1'b1;
          if (!ram_we) memRdataNext = ram_rdata;
          if (ifPending) begin
            ramWeNext   = 1'b0;
            ramAddrNext = if_addr;
            stateNext   = IF_BUSY;
          end else begin
            ramReqNext = 1'b0;
            stateNext  = IDLE;
          end
        end
      end

      IF_BUSY: begin
        if (ram_ack) begin
          ifDoneNext  = 1'b1;
          ifInstrNext = ram_rdata;
          if (memPending) begin
            ramWeNext    = mem_write;
            ramAddrNext  = mem_addr;
            ramWdataNext = mem_wdata;
            stateNext    = MEM_BUSY;
          end else begin
            ramReqNext = 1'b0;
            stateNext  = IDLE;
          end
        end
      end

      default: begin
        ramReqNext = 1'b0;
        stateNext  = IDLE;
      end
    endcase

    // A pipeline-cycle boundary wins over a late ack of an abandoned fetch,
    // so the next cycle's request is never considered already served.
    if (boundary) begin
      ifDoneNext  = 1'b0;
      memDoneNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ram_req         <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      if_instr        <= '0;
      mem_rdata       <= '0;
      ifDone          <= 1'b0;
      memDone         <= 1'b0;
      stall_cycles    <= '0;
      conflict_cycles <= '0;
    end else begin
      state     <= stateNext;
      ram_req   <= ramReqNext;
      ram_we    <= ramWeNext;
      ram_addr  <= ramAddrNext;
      ram_wdata <= ramWdataNext;
      if_instr  <= ifInstrNext;
      mem_rdata <= memRdataNext;
      ifDone    <= ifDoneNext;
      memDone   <= memDoneNext;
      if (stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end else if (if_req && memReq) begin
        conflict_cycles <= conflict_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table, hand-written corner sequences and
// random pipeline cycles checked against a per-pipeline-cycle transaction model.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, mem_read, mem_write;
  logic [AW-1:0] if_addr, mem_addr, ram_addr;
  logic [DW-1:0] mem_wdata, if_instr, mem_rdata, ram_wdata, ram_rdata;
  logic          stall, ram_req, ram_we, ram_ack;
  logic [CW-1:0] stall_cycles, conflict_cycles;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_instr(if_instr), .mem_rdata(mem_rdata), .stall(stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_cycles(stall_cycles), .conflict_cycles(conflict_cycles)
  );

  function automatic logic [31:0] initWord(input int unsigned idx);
    case (idx)
      0:       return 32'h20080005;
      1:       return 32'h2009000A;
      2:       return 32'h8C0A0040;
      3:       return 32'hAC0B0044;
      16:      return 32'hDEADBEEF;
      default: return 32'hA5000000 ^ (idx * 32'h00010101);
    endcase
  endfunction

  // RAM environment: acks after waitStates extra cycles of ram_req, tolerates ram_req dropping.
  logic [31:0] ramArr [0:255];
  int waitStates = 0;
  int waitCnt = 0;
  int ramAccesses = 0;
  assign ram_ack   = ram_req && (waitCnt == waitStates);
  assign ram_rdata = ramArr[ram_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 256; i++) ramArr[i] <= initWord(i);
      waitCnt <= 0;
    end else if (ram_req && ram_ack) begin
      ramAccesses <= ramAccesses + 1;
      if (ram_we) ramArr[ram_addr[9:2]] <= ram_wdata;
      waitCnt <= 0;
    end else if (ram_req) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Results of the last pipeline cycle run by doCycle
  int          nStall, nAcc;
  bit          firstSeen, unstable, timedOut;
  logic        firstWe;
  logic [31:0] firstAddr, firstWdata;

  task automatic doCycle(input bit ir, input logic [31:0] ia, input bit rd, input bit wr,
                         input logic [31:0] ma, input logic [31:0] wd, input int w);
    int acc0;
    bit prevHold;
    logic [31:0] pA, pD;
    logic pW;
    waitStates = w;
    if_req = ir; if_addr = ia;
    mem_read = rd; mem_write = wr; mem_addr = ma; mem_wdata = wd;
    acc0 = ramAccesses;
    nStall = 0; firstSeen = 0; unstable = 0; timedOut = 0; prevHold = 0;
    pA = '0; pD = '0; pW = 1'b0;
    @(negedge clk);
    while (stall !== 1'b0) begin
      nStall++;
      if (ram_req) begin
        if (!firstSeen) begin
          firstSeen = 1; firstAddr = ram_addr; firstWe = ram_we; firstWdata = ram_wdata;
        end
        if (prevHold && (ram_addr !== pA || ram_we !== pW || ram_wdata !== pD)) unstable = 1;
        prevHold = !ram_ack; pA = ram_addr; pW = ram_we; pD = ram_wdata;
      end else begin
        prevHold = 0;
      end
      if (nStall > 100) begin timedOut = 1; break; end
      @(negedge clk);
    end
    nAcc = ramAccesses - acc0;
  endtask

  typedef struct {
    bit          ifReq;
    logic [31:0] ifAddr;
    bit          rd, wr;
    logic [31:0] memAddr, wdata;
    int          w;
    int          expStall;
    logic [31:0] expInstr, expRdata;
    int          expSc, expCc;
  } vec_t;

  vec_t vecs[11];
  logic [31:0] refMem [0:255];
  logic [31:0] mInstr, mRdata;
  int mSc, mCc;

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ir, rd, wr;
    logic [31:0] ia, ma, wd;
    int w, n, expStall, lim;
    vec_t v;

    vecs[0]  = '{1, 32'h00, 0, 0, 32'h00, 32'h0,        0, 2, 32'h20080005, 32'h00000000,  2, 0};
    vecs[1]  = '{1, 32'h04, 0, 0, 32'h00, 32'h0,        0, 2, 32'h2009000A, 32'h00000000,  4, 0};
    vecs[2]  = '{1, 32'h08, 1, 0, 32'h40, 32'h0,        0, 3, 32'h8C0A0040, 32'hDEADBEEF,  7, 1};
    vecs[3]  = '{1, 32'h0C, 0, 1, 32'h44, 32'h12345678, 0, 3, 32'hAC0B0044, 32'hDEADBEEF, 10, 2};
    vecs[4]  = '{0, 32'h00, 1, 0, 32'h44, 32'h0,        0, 2, 32'hAC0B0044, 32'h12345678, 12, 2};
    vecs[5]  = '{1, 32'h00, 1, 0, 32'h40, 32'h0,        3, 9, 32'h20080005, 32'hDEADBEEF, 21, 3};
    vecs[6]  = '{1, 32'h48, 0, 1, 32'h48, 32'hCAFEF00D, 1, 5, 32'hCAFEF00D, 32'hDEADBEEF, 26, 4};
    vecs[7]  = '{0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 32'hCAFEF00D, 32'hDEADBEEF, 26, 4};
    vecs[8]  = '{1, 32'h04, 0, 0, 32'h00, 32'h0,        2, 4, 32'h2009000A, 32'hDEADBEEF, 30, 4};
    vecs[9]  = '{0, 32'h00, 1, 1, 32'h4C, 32'h0BADC0DE, 0, 2, 32'h2009000A, 32'hDEADBEEF, 32, 4};
    vecs[10] = '{0, 32'h00, 1, 0, 32'h4C, 32'h0,        0, 2, 32'h2009000A, 32'h0BADC0DE, 34, 4};

    for (int unsigned i = 0; i < 256; i++) refMem[i] = initWord(i);

    reset = 1'b1;
    if_req = 0; if_addr = '0; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_stall", stall, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_conflict_cycles", conflict_cycles, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      doCycle(v.ifReq, v.ifAddr, v.rd, v.wr, v.memAddr, v.wdata, v.w);
      check($sformatf("vec%0d_timeout", i), timedOut, 0);
      check($sformatf("vec%0d_stall_len", i), nStall, v.expStall);
      check($sformatf("vec%0d_if_instr", i), if_instr, v.expInstr);
      check($sformatf("vec%0d_mem_rdata", i), mem_rdata, v.expRdata);
      check($sformatf("vec%0d_accesses", i), nAcc, int'(v.ifReq) + int'(v.rd | v.wr));
      check($sformatf("vec%0d_ram_stable", i), unstable, 0);
      if (v.wr) begin
        check($sformatf("vec%0d_store_we", i), firstWe, 1);
        check($sformatf("vec%0d_store_addr", i), firstAddr, v.memAddr);
        check($sformatf("vec%0d_store_wdata", i), firstWdata, v.wdata);
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d_stall_cycles", i), stall_cycles, v.expSc);
      check($sformatf("vec%0d_conflict_cycles", i), conflict_cycles, v.expCc);
      if (v.wr) refMem[v.memAddr[9:2]] = v.wdata;
    end

    mInstr = vecs[10].expInstr;
    mRdata = vecs[10].expRdata;
    mSc    = vecs[10].expSc;
    mCc    = vecs[10].expCc;

    // Random pipeline cycles: each cycle serves MEM then IF, each access costing w+1 cycles
    // after one issue cycle.
    for (int unsigned k = 0; k < 60; k++) begin
      ir = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      ia = 32'($urandom_range(0, 63)) * 4;
      ma = 32'($urandom_range(0, 63)) * 4;
      wd = $urandom;
      w  = int'($urandom_range(0, 3));
      n  = int'(ir) + int'(rd | wr);
      expStall = (n == 0) ? 0 : 1 + n * (w + 1);
      if (wr) refMem[ma[9:2]] = wd;
      else if (rd) mRdata = refMem[ma[9:2]];
      if (ir) mInstr = refMem[ia[9:2]];
      mSc += expStall;
      if (ir && (rd || wr)) mCc++;
      doCycle(ir, ia, rd, wr, ma, wd, w);
      check($sformatf("rnd%0d_timeout", k), timedOut, 0);
      check($sformatf("rnd%0d_stall_len", k), nStall, expStall);
      check($sformatf("rnd%0d_if_instr", k), if_instr, mInstr);
      check($sformatf("rnd%0d_mem_rdata", k), mem_rdata, mRdata);
      check($sformatf("rnd%0d_accesses", k), nAcc, n);
      check($sformatf("rnd%0d_ram_stable", k), unstable, 0);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_stall_cycles", k), stall_cycles, mSc);
      check($sformatf("rnd%0d_conflict_cycles", k), conflict_cycles, mCc);
    end

    // Redirect while a fetch is in flight: 0x10 completes, then 0x30 is fetched.
    begin
      int acc0;
      acc0 = ramAccesses;
      waitStates = 2;
      if_req = 1; if_addr = 32'h10; mem_read = 0; mem_write = 0;
      lim = 0;
      @(negedge clk);
      while (ram_req !== 1'b1 && lim < 20) begin lim++; @(negedge clk); end
      check("redir_issue_timeout", lim < 20, 1);
      check("redir_issue_addr", ram_addr, 32'h10);
      if_addr = 32'h30;
      lim = 0;
      while (stall !== 1'b0 && lim < 20) begin lim++; @(negedge clk); end
      check("redir_done_timeout", lim < 20, 1);
      check("redir_first_instr", if_instr, refMem[4]);
      check("redir_first_accesses", ramAccesses - acc0, 1);
      @(posedge clk); #1;
      doCycle(1, 32'h30, 0, 0, 32'h0, 32'h0, 2);
      check("redir_second_timeout", timedOut, 0);
      check("redir_second_stall_len", nStall, 4);
      check("redir_second_instr", if_instr, refMem[12]);
      check("redir_total_accesses", ramAccesses - acc0, 2);
      @(posedge clk); #1;
    end

    // Synchronous reset while a load is in flight.
    waitStates = 3;
    if_req = 0; mem_read = 1; mem_write = 0; mem_addr = 32'h40;
    lim = 0;
    @(negedge clk);
    while (ram_req !== 1'b1 && lim < 20) begin lim++; @(negedge clk); end
    check("rstbusy_issue_timeout", lim < 20, 1);
    reset = 1'b1; mem_read = 0;
    @(posedge clk); #1;
    check("rstbusy_ram_req", ram_req, 0);
    check("rstbusy_stall", stall, 0);
    check("rstbusy_stall_cycles", stall_cycles, 0);
    check("rstbusy_conflict_cycles", conflict_cycles, 0);
    check("rstbusy_if_instr", if_instr, 0);
    check("rstbusy_mem_rdata", mem_rdata, 0);
    reset = 1'b0;
    for (int unsigned i = 0; i < 256; i++) refMem[i] = initWord(i);

    doCycle(1, 32'h00, 0, 0, 32'h0, 32'h0, 0);
    check("post_rst_timeout", timedOut, 0);
    check("post_rst_stall_len", nStall, 2);
    check("post_rst_if_instr", if_instr, refMem[0]);
    check("post_rst_mem_rdata", mem_rdata, 0);
    @(posedge clk); #1;
    check("post_rst_stall_cycles", stall_cycles, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
